gcd_controller: RTL and testbench

Control FSM for the subtract-and-compare GCD datapath. Accepts two operands over a valid/ready handshake, drives the datapath load and select strobes through one subtraction per cycle, and reports completion and iteration count. Sits directly beside the datapath on the shared GCD interface. It consumes the datapath's `lt`/`gt`/`eq` flags and produces every datapath control.

---
 rtl/gcd_controller.sv | 160 ++++++++++++++++
 tb/tb_gcd_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for the subtract-and-compare GCD datapath (rev 1.0).
// Optional iteration limit enabled by defining GCD_CTRL_TIMEOUT_EN.
`default_nettype none

module gcd_controller #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             lt_i,
  input  logic             gt_i,
  input  logic             eq_i,
  output logic             in_ready_o,
  output logic             ldA_o,
  output logic             ldB_o,
  output logic             sel1_o,
  output logic             sel2_o,
  output logic             sel_in_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] iter_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ITER   = 3'd3,
    S_FIXUP  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             a_zero_q;
  logic [CNT_W-1:0] iter_cnt_q;
  logic [CNT_W-1:0] iter_cnt_d;
  logic             timeout_hit;
  logic             data_zero;

  assign data_zero = (data_in_i == '0);

`ifdef GCD_CTRL_TIMEOUT_EN
  assign timeout_hit = (iter_cnt_q == CNT_W'(MAX_ITER)) && !eq_i;
`else
  logic unused_max_iter;
  assign unused_max_iter = (MAX_ITER != 0);
  assign timeout_hit     = 1'b0;
`endif

  // Saturating count: never wraps back to zero on very long runs.
  assign iter_cnt_d = (iter_cnt_q == {CNT_W{1'b1}}) ? iter_cnt_q : iter_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      a_zero_q   <= 1'b0;
      iter_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_LOAD_A;
            iter_cnt_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD_A: begin
          if (in_valid_i) begin
            a_zero_q <= data_zero;
            state_q  <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (in_valid_i) begin
            if (data_zero)     state_q <= S_DONE;
            else if (a_zero_q) state_q <= S_FIXUP;
            else               state_q <= S_ITER;
          end
        end
        S_ITER: begin
          if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (eq_i) begin
            state_q <= S_DONE;
          end else if (gt_i || lt_i) begin
            iter_cnt_q <= iter_cnt_d;
          end
        end
        S_FIXUP: state_q <= S_DONE;
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath strobes follow the current state and compare flags directly.
  always_comb begin
    in_ready_o = 1'b0;
    ldA_o      = 1'b0;
    ldB_o      = 1'b0;
    sel1_o     = 1'b0;
    sel2_o     = 1'b0;
    sel_in_o   = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        in_ready_o = 1'b1;
        ldA_o      = in_valid_i;
        sel_in_o   = in_valid_i;
      end
      S_LOAD_B: begin
        in_ready_o = 1'b1;
        ldB_o      = in_valid_i;
        sel_in_o   = in_valid_i;
      end
      S_ITER: begin
        if (!timeout_hit && !eq_i) begin
          if (gt_i) begin
            ldA_o  = 1'b1;
            sel2_o = 1'b1;
          end else if (lt_i) begin
            ldB_o  = 1'b1;
            sel1_o = 1'b1;
          end
        end
      end
      S_FIXUP: begin
        ldA_o  = 1'b1;
        sel1_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign iter_cnt_o = iter_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed and random GCD runs against a Euclid-based reference model.
`default_nettype none

module tb_gcd_controller;
  localparam int WIDTH  = 16;
  localparam int CNT_W  = 16;
  localparam int TB_MAX = 8;
`ifdef GCD_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic [WIDTH-1:0] data_in_i = '0;
  logic             lt_i, gt_i, eq_i;
  logic             in_ready_o, ldA_o, ldB_o, sel1_o, sel2_o, sel_in_o;
  logic             busy_o, done_o, err_o;
  logic [CNT_W-1:0] iter_cnt_o;

  logic [WIDTH-1:0] dpA = '0;
  logic [WIDTH-1:0] dpB = '0;
  logic [WIDTH-1:0] sub;

  int n_assert = 0;
  int n_fail   = 0;

  gcd_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_ITER(TB_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_valid_i(in_valid_i),
    .data_in_i(data_in_i), .lt_i(lt_i), .gt_i(gt_i), .eq_i(eq_i),
    .in_ready_o(in_ready_o), .ldA_o(ldA_o), .ldB_o(ldB_o), .sel1_o(sel1_o),
    .sel2_o(sel2_o), .sel_in_o(sel_in_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .iter_cnt_o(iter_cnt_o)
  );

  always #5 clk = ~clk;

  // Simple datapath beside the controller: two registers, a subtractor and a comparator.
  assign sub  = (sel1_o ? dpB : dpA) - (sel2_o ? dpB : dpA);
  assign lt_i = dpA < dpB;
  assign gt_i = dpA > dpB;
  assign eq_i = dpA == dpB;

  always @(posedge clk) begin
    if (ldA_o) dpA <= sel_in_o ? data_in_i : sub;
    if (ldB_o) dpB <= sel_in_o ? data_in_i : sub;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // GCD and subtraction count from Euclid's quotients: each quotient q is q
  // subtractions, except the final step stops once the pair is equal.
  function automatic void ref_gcd(input int a, input int b, output int g, output int n);
    int x, y, r;
    n = 0;
    if (b == 0) g = a;
    else if (a == 0) g = b;
    else begin
      x = (a > b) ? a : b;
      y = (a > b) ? b : a;
      while (y != 0) begin
        n += x / y;
        r  = x % y;
        x  = y;
        y  = r;
      end
      n -= 1;
      g  = x;
    end
  endfunction

  task automatic run(input int a, input int b, input int stall, input bit poke, input bit chk_seq);
    int g, n, exp_cnt, exp_lat, k;
    bit exp_err;
    int seqA[4] = '{30, 12, 12, 6};
    int seqB[4] = '{18, 18, 6, 6};
    ref_gcd(a, b, g, n);
    exp_err = TO_EN && (b != 0) && (a != 0) && (n > TB_MAX);
    exp_cnt = exp_err ? TB_MAX : n;
    if (b == 0)      exp_lat = 4;
    else if (a == 0) exp_lat = 5;
    else             exp_lat = exp_cnt + 5;
    exp_lat += stall;

    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    k = 1;
    check("in_ready_load_a", in_ready_o, 1);
    check("busy_set", busy_o, 1);
    check("iter_cleared", iter_cnt_o, 0);
    check("err_cleared", err_o, 0);
    in_valid_i = 1'b1;
    data_in_i  = WIDTH'(a);
    @(negedge clk) k++;
    in_valid_i = 1'b0;
    data_in_i  = WIDTH'($urandom);
    repeat (stall) begin
      #1;
      check("stall_ready", in_ready_o, 1);
      check("stall_noload", {ldA_o, ldB_o}, 0);
      @(negedge clk) k++;
    end
    in_valid_i = 1'b1;
    data_in_i  = WIDTH'(b);
    @(negedge clk) k++;
    while (!done_o && k < exp_lat + 50) begin
      in_valid_i = 1'($urandom_range(0, 1));
      data_in_i  = WIDTH'($urandom);
      start_i    = poke && (k == 5);
      if (chk_seq && k >= 4 && k <= 7) begin
        check("seq_A", dpA, seqA[k-4]);
        check("seq_B", dpB, seqB[k-4]);
      end
      @(negedge clk) k++;
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    check("done_seen", done_o, 1);
    check("latency", k, exp_lat);
    check("busy_dropped", busy_o, 0);
    check("iter_cnt", iter_cnt_o, exp_cnt);
    check("err", err_o, exp_err);
    if (!exp_err) check("result", dpA, g);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("err_held", err_o, exp_err);
    if (!exp_err) check("result_held", dpA, g);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {in_ready_o, ldA_o, ldB_o, sel1_o, sel2_o, sel_in_o, busy_o, done_o, err_o}, 0);
    check({tag, "_cnt"}, iter_cnt_o, 0);
  endtask

  initial begin
    int ra, rb;
    @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");

    run(48, 18, 0, 1'b0, 1'b1);
    run(0, 7, 0, 1'b0, 1'b0);
    run(9, 0, 0, 1'b0, 1'b0);
    run(0, 0, 0, 1'b0, 1'b0);
    run(48, 18, 3, 1'b0, 1'b0);
    run(48, 18, 0, 1'b1, 1'b1);
    run(100, 1, 0, 1'b0, 1'b0);
    run(10, 4, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom_range(0, 200);
      rb = $urandom_range(0, 200);
      run(ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset in the middle of a long run.
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) begin start_i = 1'b0; in_valid_i = 1'b1; data_in_i = 16'hFFFF; end
    @(negedge clk) data_in_i = 16'd1;
    @(negedge clk) in_valid_i = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_before_reset", busy_o, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk) rst_n = 1'b1;
    run(21, 14, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
